// File: rtl/seq_pkg.sv
// seq_pkg
// Shared definitions for the word serializer that feeds the 110/101
// sequence detector: the serializer state type, its encoding constants and
// the default word width (also used by the detector bench).
package seq_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } ser_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_word_serializer.sv
// seq_word_serializer
// Accepts parallel words over a valid/ready handshake and shifts them out one
// bit per clock on a single serial line. Words stream back to back with no
// idle gap; the line is 0 whenever no word is in flight.
//
// Parameters
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
// Ports
//   clk          rising-edge clock
//   rstn         synchronous reset, active HIGH despite the name
//   din          parallel word
//   din_valid    din is offered
//   din_ready    word is accepted this cycle (combinational)
//   x            serial bit (registered)
//   x_valid      x carries a word bit (registered)
//   frame_start  x is the first bit of a word (registered)
//   frame_last   x is the last bit of a word (registered)
module seq_word_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept;
  logic             x_nxt, x_valid_nxt, frame_start_nxt, frame_last_nxt;

  // Ready only when idle or on the last bit of the current word, so a waiting
  // word is picked up exactly as the previous one finishes.
  always_comb begin
    din_ready = !rstn && (state == IDLE || (state == SHIFT && cnt == '0));
  end

  assign accept = din_valid && din_ready;

  // Next-state / datapath logic
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    if (accept) begin
      shreg_nxt = din;
      cnt_nxt   = CNT_LOAD;
      state_nxt = SHIFT;
    end else if (state == SHIFT) begin
      if (cnt != '0) begin
        // Shift toward the output end, zero fill.
        shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        cnt_nxt   = cnt - 1'b1;
      end else begin
        shreg_nxt = '0;
        state_nxt = IDLE;
      end
    end
  end

  // Output logic: computed from next-state values so every output is a flop
  // that lines up with the state it describes.
  always_comb begin
    x_nxt           = 1'b0;
    x_valid_nxt     = 1'b0;
    frame_start_nxt = 1'b0;
    frame_last_nxt  = 1'b0;
    if (state_nxt == SHIFT) begin
      x_nxt           = MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0];
      x_valid_nxt     = 1'b1;
      frame_start_nxt = accept;
      frame_last_nxt  = (cnt_nxt == '0);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rstn) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      cnt         <= cnt_nxt;
      x           <= x_nxt;
      x_valid     <= x_valid_nxt;
      frame_start <= frame_start_nxt;
      frame_last  <= frame_last_nxt;
    end
  end

endmodule

// File: tb/tb_seq_word_serializer.sv
// tb_seq_word_serializer
// Table-driven bench for seq_word_serializer with three configurations:
// A = WIDTH 8 MSB first, B = WIDTH 8 LSB first, C = WIDTH 2 MSB first.
// Each table row drives one instance for one cycle and checks
// {din_ready, x, x_valid, frame_start, frame_last} on the falling edge.
module tb_seq_word_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_a, din_b;
  logic [1:0] din_c;
  logic       vld_a, vld_b, vld_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic       x_a, x_b, x_c;
  logic       xv_a, xv_b, xv_c;
  logic       fs_a, fs_b, fs_c;
  logic       fl_a, fl_b, fl_c;

  always #5 clk = ~clk;

  seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rstn(rst), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .x(x_a), .x_valid(xv_a), .frame_start(fs_a), .frame_last(fl_a));

  seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rstn(rst), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .x(x_b), .x_valid(xv_b), .frame_start(fs_b), .frame_last(fl_b));

  seq_word_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rstn(rst), .din(din_c), .din_valid(vld_c), .din_ready(rdy_c),
    .x(x_c), .x_valid(xv_c), .frame_start(fs_c), .frame_last(fl_c));

  typedef struct {
    int         sel;
    logic       rst;
    logic       vld;
    logic [7:0] din;
    logic [4:0] exp;   // {ready, x, x_valid, frame_start, frame_last}
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   accepts = 0;

  task automatic add(input int s, input logic r, input logic v, input logic [7:0] d,
                     input logic rd, input logic xx, input logic xv,
                     input logic fs, input logic fl);
    vec_t e;
    e.sel = s; e.rst = r; e.vld = v; e.din = d; e.exp = {rd, xx, xv, fs, fl};
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic build_table();
    // A: reset with a word offered, then single word 1011_0000 MSB first
    add(0,1,1,8'hB0, 0,0,0,0,0);
    add(0,1,1,8'hB0, 0,0,0,0,0);
    add(0,0,1,8'hB0, 1,0,0,0,0);
    add(0,0,0,8'h00, 0,1,1,1,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,1,1,0,0);
    add(0,0,0,8'h00, 0,1,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 1,0,1,0,1);
    add(0,0,0,8'h00, 1,0,0,0,0);
    add(0,0,0,8'h00, 1,0,0,0,0);
    // B: back-to-back 06 then 05, LSB first, valid held high
    add(1,1,0,8'h00, 0,0,0,0,0);
    add(1,0,1,8'h06, 1,0,0,0,0);
    add(1,0,1,8'h05, 0,0,1,1,0);
    add(1,0,1,8'h05, 0,1,1,0,0);
    add(1,0,1,8'h05, 0,1,1,0,0);
    add(1,0,1,8'h05, 0,0,1,0,0);
    add(1,0,1,8'h05, 0,0,1,0,0);
    add(1,0,1,8'h05, 0,0,1,0,0);
    add(1,0,1,8'h05, 0,0,1,0,0);
    add(1,0,1,8'h05, 1,0,1,0,1);
    add(1,0,0,8'h00, 0,1,1,1,0);
    add(1,0,0,8'h00, 0,0,1,0,0);
    add(1,0,0,8'h00, 0,1,1,0,0);
    add(1,0,0,8'h00, 0,0,1,0,0);
    add(1,0,0,8'h00, 0,0,1,0,0);
    add(1,0,0,8'h00, 0,0,1,0,0);
    add(1,0,0,8'h00, 0,0,1,0,0);
    add(1,0,0,8'h00, 1,0,1,0,1);
    add(1,0,0,8'h00, 1,0,0,0,0);
    // A: backpressure, C3 in flight, A5 offered on bit 3 and held
    add(0,1,0,8'h00, 0,0,0,0,0);
    add(0,0,1,8'hC3, 1,0,0,0,0);
    add(0,0,0,8'h00, 0,1,1,1,0);
    add(0,0,0,8'h00, 0,1,1,0,0);
    add(0,0,1,8'hA5, 0,0,1,0,0);
    add(0,0,1,8'hA5, 0,0,1,0,0);
    add(0,0,1,8'hA5, 0,0,1,0,0);
    add(0,0,1,8'hA5, 0,0,1,0,0);
    add(0,0,1,8'hA5, 0,1,1,0,0);
    add(0,0,1,8'hA5, 1,1,1,0,1);
    add(0,0,0,8'h00, 0,1,1,1,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,1,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,1,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 1,1,1,0,1);
    add(0,0,0,8'h00, 1,0,0,0,0);
    // A: reset after bit 4 of FF, word offered during reset is ignored
    add(0,1,0,8'h00, 0,0,0,0,0);
    add(0,0,1,8'hFF, 1,0,0,0,0);
    add(0,0,0,8'h00, 0,1,1,1,0);
    add(0,0,0,8'h00, 0,1,1,0,0);
    add(0,0,0,8'h00, 0,1,1,0,0);
    add(0,1,1,8'h81, 0,1,1,0,0);
    add(0,0,1,8'h81, 1,0,0,0,0);
    add(0,0,0,8'h00, 0,1,1,1,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 0,0,1,0,0);
    add(0,0,0,8'h00, 1,1,1,0,1);
    add(0,0,0,8'h00, 1,0,0,0,0);
    // C: WIDTH 2, stream 10, 01, 11
    add(2,1,0,8'h00, 0,0,0,0,0);
    add(2,0,1,8'h02, 1,0,0,0,0);
    add(2,0,1,8'h01, 0,1,1,1,0);
    add(2,0,1,8'h01, 1,0,1,0,1);
    add(2,0,1,8'h03, 0,0,1,1,0);
    add(2,0,1,8'h03, 1,1,1,0,1);
    add(2,0,0,8'h00, 0,1,1,1,0);
    add(2,0,0,8'h00, 1,1,1,0,1);
    add(2,0,0,8'h00, 1,0,0,0,0);
  endtask

  initial begin
    vec_t       v;
    logic [4:0] got;
    logic [7:0] words [3];
    logic [23:0] bits;
    int nbits, nfs, nacc, first_cyc, last_cyc, idx;
    logic took;

    rst = 1'b1;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    build_table();
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rst = v.rst;
      vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
      din_a = '0; din_b = '0; din_c = '0;
      case (v.sel)
        0:       begin vld_a = v.vld; din_a = v.din; end
        1:       begin vld_b = v.vld; din_b = v.din; end
        default: begin vld_c = v.vld; din_c = v.din[1:0]; end
      endcase
      @(negedge clk);
      case (v.sel)
        0:       got = {rdy_a, x_a, xv_a, fs_a, fl_a};
        1:       got = {rdy_b, x_b, xv_b, fs_b, fl_b};
        default: got = {rdy_c, x_c, xv_c, fs_c, fl_c};
      endcase
      if (got[4] && v.vld) accepts++;
      check($sformatf("row%0d_dut%0d", i, v.sel), 32'(got), 32'(v.exp));
      @(posedge clk); #1;
    end
    check("table_accepts", 32'(accepts), 32'd10);

    // B: three words streamed with valid held high; bits must be contiguous.
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    rst = 1'b0; vld_a = 1'b0; vld_c = 1'b0;
    vld_b = 1'b1; din_b = words[0];
    idx = 0; nbits = 0; nfs = 0; nacc = 0; bits = '0;
    first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 40 && nbits < 24; cyc++) begin
      @(negedge clk);
      took = rdy_b && vld_b;
      if (took) nacc++;
      if (xv_b) begin
        bits[nbits] = x_b;
        nbits++;
        if (fs_b) nfs++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 3) din_b = words[idx];
        else vld_b = 1'b0;
      end
    end
    vld_b = 1'b0;
    check("stream_bitcount", 32'(nbits), 32'd24);
    check("stream_bits", 32'(bits), 32'h00FF8001);
    check("stream_starts", 32'(nfs), 32'd3);
    check("stream_accepts", 32'(nacc), 32'd3);
    check("stream_no_gap", 32'(last_cyc - first_cyc + 1), 32'd24);
    repeat (2) @(posedge clk);
    #1;
    check("stream_idle_x", 32'({x_b, xv_b}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_word_serializer.md
# seq_word_serializer

Upstream feeder for the 110/101 sequence detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a single serial line. That line drives the detector's `x` input directly. Back-to-back words stream with no idle gap, and the line is held at 0 whenever no word is in flight.

## Interface
- `WIDTH`, default 8: bits per word. Legal range is WIDTH >= 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- `clk` input, 1 bit: single clock, rising edge.
- `rstn` input, 1 bit: synchronous, active-high reset. rstn=1 resets on the next rising edge of `clk`.
- `din` input, WIDTH bits: parallel word.
- `din_valid` input, 1 bit: `din` is offered.
- `din_ready` output, 1 bit: the block accepts `din` this cycle.
- `x` output, 1 bit: serial bit, registered.
- `x_valid` output, 1 bit: `x` carries a word bit, registered.
- `frame_start` output, 1 bit: `x` is the first bit of a word, registered.
- `frame_last` output, 1 bit: `x` is the last bit of a word, registered.

## Operation
- **State machine.** Two states:
  - IDLE: no word in flight.
  - SHIFT: bits of the current word are being sent.
- **Register set.**
  - `shreg` is WIDTH bits wide.
  - `cnt` is $clog2(WIDTH) bits wide and counts the bits remaining after the current one.
- **Ready logic.** `din_ready = !rstn && (state==IDLE || (state==SHIFT && cnt==0))`. It is combinational from state and cnt and does not depend on `din_valid`.
- **Accept.** A word is accepted when `din_valid && din_ready`. On accept:
  - `shreg` loads `din`.
  - `cnt` loads WIDTH-1.
  - The next state is SHIFT.
- **SHIFT with cnt > 0.** Each cycle `shreg` shifts toward the output end, filling with 0, and `cnt` decrements.
- **SHIFT with cnt == 0, last bit on the line.**
  - If a word is accepted, it reloads and the state stays SHIFT, so there is no gap.
  - Otherwise the next state is IDLE.
- **Serial output.** `x` shows `shreg[WIDTH-1]` when MSB_FIRST, otherwise `shreg[0]`, and only while in SHIFT. In IDLE, `x`=0 and `x_valid`=0.
- **Frame flags.**
  - `frame_start`=1 in the first SHIFT cycle after each accept.
  - `frame_last`=1 when SHIFT and cnt==0.
- **Upstream protocol.** `din` and `din_valid` must hold stable while `din_valid && !din_ready`. The block never drops or duplicates a word.
- **Detector coupling.** The detector has no valid qualifier and treats the 0s on idle cycles as data. This is intended: gaps look like 0 bits.

## Timing
- **Reset values.** state=IDLE, shreg=0, cnt=0, x=0, x_valid=0, frame_start=0, frame_last=0. `din_ready`=0 while rstn=1.
- **Latency.** A word accepted at edge N puts its first bit on `x` for the cycle after edge N. Its last bit is on `x` after edge N+WIDTH-1.
- **Throughput.** One bit per clock, continuous across words. One word per WIDTH cycles at steady state.
- **Accept and last bit in the same cycle.** Word k+1's first bit follows word k's last bit on the next cycle. `frame_last` and `frame_start` are then high on consecutive cycles.
- **Reset mid-word.** rstn=1 at any edge aborts the word in flight with no partial completion. `x` is 0 on the following cycle. A word offered during reset is not accepted.
- **Backpressure.** Mid-word (cnt>0), `din_ready`=0. The offered word waits and is accepted on the last-bit cycle.

## Structure
- **Package `seq_pkg`.**
  - State typedef: `ser_state_t` {IDLE, SHIFT}.
  - Encoding constants.
  - Default WIDTH constant, shared with the detector bench.
- **Sub-modules.** None. The counter and shifter are small and stay in one flat module.

## Test plan
- **Reset.** Assert rstn for 2 cycles with `din_valid`=1 -> `din_ready`=0, `x`=0, `x_valid`=0, no accept. Deassert -> `din_ready`=1.
- **Single word, MSB first.** WIDTH=8, MSB_FIRST=1, send `din`=8'b1011_0000 -> `x` = 1,0,1,1,0,0,0,0 on the 8 cycles after accept. `frame_start` on cycle 1, `frame_last` on cycle 8. Then IDLE and `x`=0. The chained detector pulses `y` for 101.
- **Back-to-back words, LSB first.** MSB_FIRST=0, `din_valid` held high with 8'h06 then 8'h05 -> `x` = 0,1,1,0,0,0,0,0,1,0,1,0,0,0,0,0 with no gap. `din_ready` is high only on cycles 0, 8 and 16.
- **Backpressure.** Offer 8'hA5 at cycle 3 of a word -> word held, accepted exactly on that word's `frame_last` cycle. Bits follow contiguously. Count accepts against words sent: equal.
- **Reset mid-word.** Assert rstn after bit 4 of 8'hFF -> `x`=0 and `x_valid`=0 the next cycle. After deassert, the next word serializes from its first bit.
- **Minimum width.** WIDTH=2, stream 2'b10, 2'b01, 2'b11 -> `x` = 1,0,0,1,1,1 with `frame_start`/`frame_last` alternating every cycle.
